mem_access_split: RTL and testbench
===================================

Name: mem_access_split

Overview:
- Memory-access stage driver for the 16-bit data memory port.
- Turns 32-bit load/store requests from execute into one or two 16-bit memory accesses: low half at addr, then high half at addr+2.
- It is the issuing end of the two-beat protocol that write-back consumes. A word load presents low then high on consecutive cycles, with mem_to_reg asserted.
- Stalls the upstream pipeline while a second beat is pending.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, request data width
MEM_W, 16, data memory port width (DATA_W = 2*MEM_W fixed)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-high reset
req_valid_i  in  1  request present this cycle
req_write_i  in  1  1=store, 0=load
req_word_i  in  1  1=32-bit access, 0=16-bit access
req_addr_i  in  32  byte address
req_wdata_i  in  32  store data
stall_o  in→out  1  hold upstream (combinational)
misaligned_o  out  1  one-cycle error pulse, addr[0]=1
data_mem_addr_o  out  32  memory address
data_mem_wdata_o  out  16  memory write data
data_mem_we_o  out  1  write enable, sampled at rising edge
data_mem_re_o  out  1  read enable
mem_to_reg_o  out  1  load beat active, to write-back
(stall_o direction is out.)

Behaviour:
Interface:
- One clock, clk_i.
- Reset rst_i is asynchronous and active-high.
- Memory reads are combinational, with data valid in the same cycle. Writes commit at the rising edge.

Reset values:
- state=ST_IDLE.
- Every output 0.
- Latched high half and address cleared.

States:
- ST_IDLE:
  - No req_valid_i: all strobes 0, data_mem_addr_o=0.
  - req_valid_i with req_addr_i[0]=1: misaligned_o=1 this cycle, no we/re, no stall. Stay in ST_IDLE.
  - Half access: data_mem_addr_o=req_addr_i, wdata=req_wdata_i[15:0], we=req_write_i, re=~req_write_i, mem_to_reg_o=~req_write_i. Stay in ST_IDLE. Zero added latency.
  - Word access, first beat: same as half access, plus stall_o=1. Register hi_data=req_wdata_i[31:16], hi_addr=req_addr_i+2 (mod 2^32, so 0xFFFFFFFE wraps to 0x00000000), hi_write=req_write_i. Next state is ST_HIGH.
- ST_HIGH, second beat, driven only from registers:
  - data_mem_addr_o=hi_addr, wdata=hi_data, we=hi_write, re=~hi_write, mem_to_reg_o=~hi_write.
  - stall_o=0, so upstream advances at this edge. Next state is ST_IDLE.
  - Request inputs are ignored this cycle.
  - A new request is accepted only in the following cycle.

Other rules:
- Word load: mem_to_reg_o is high for exactly two consecutive cycles. The low half is at addr; the high half is at addr+2.
- Word store: we is high for exactly two consecutive cycles.
- Reset asserted in ST_HIGH: return to ST_IDLE immediately and asynchronously. The pending high half is dropped and no write occurs.
- A store is never split across a reset except as above. The first beat may have committed.

Decomposition:
- Shared package core_pkg holds:
  - state typedef enum {ST_IDLE, ST_HIGH}.
  - MEM_W and HALF_STEP=2 constants.
- Single module; no sub-module needed.
- The high-beat register set (hi_addr/hi_data/hi_write) stays inline.

Test Plan:
1. Store word addr=0x100, wdata=0xDEADBEEF:
   - cycle0: we=1, addr=0x100, wdata=0xBEEF, stall=1.
   - cycle1: we=1, addr=0x102, wdata=0xDEAD, stall=0.
2. Load word addr=0x40, memory 0x40=0x5678, 0x42=0x1234:
   - re and mem_to_reg high 2 cycles, addrs 0x40 then 0x42.
   - Write-back assembles 0x12345678.
3. Store half addr=0x10, wdata=0xFFFF00AA: single cycle, we=1, wdata=0x00AA, stall=0. Back-to-back half stores are accepted every cycle.
4. Word load at addr=0x103: misaligned_o=1 for one cycle, re=we=0, stall=0.
5. Word store at 0xFFFFFFFE: second beat addr=0x00000000.
6. Assert rst_i mid-cycle during ST_HIGH of a word store: outputs go 0 without a clock edge, the high half is never written, and the next request starts in ST_IDLE.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared state type and memory-port constants for the memory-access stage
package core_pkg;

    localparam int MEM_W     = 16;
    localparam int HALF_STEP = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HIGH = 1'b1
    } state_t;

endpackage

// File: rtl/mem_access_split.sv
// rtl/mem_access_split.sv - splits 32-bit load/store requests into one or two 16-bit memory beats
module mem_access_split
    import core_pkg::state_t;
    import core_pkg::ST_IDLE;
    import core_pkg::ST_HIGH;
    import core_pkg::HALF_STEP;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MEM_W  = core_pkg::MEM_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    input  logic              req_write_i,
    input  logic              req_word_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              stall_o,
    output logic              misaligned_o,
    output logic [ADDR_W-1:0] data_mem_addr_o,
    output logic [MEM_W-1:0]  data_mem_wdata_o,
    output logic              data_mem_we_o,
    output logic              data_mem_re_o,
    output logic              mem_to_reg_o
);

    state_t              state;
    logic [ADDR_W-1:0]   hi_addr;
    logic [MEM_W-1:0]    hi_data;
    logic                hi_write;

    logic aligned_req;
    assign aligned_req = req_valid_i && !req_addr_i[0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            hi_addr  <= '0;
            hi_data  <= '0;
            hi_write <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (aligned_req && req_word_i) begin
                        hi_addr  <= req_addr_i + ADDR_W'(HALF_STEP);
                        hi_data  <= req_wdata_i[DATA_W-1:MEM_W];
                        hi_write <= req_write_i;
                        state    <= ST_HIGH;
                    end
                end
                ST_HIGH: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs are gated by reset so a reset during the high beat silences the port without an edge.
    always_comb begin
        stall_o          = 1'b0;
        misaligned_o     = 1'b0;
        data_mem_addr_o  = '0;
        data_mem_wdata_o = '0;
        data_mem_we_o    = 1'b0;
        data_mem_re_o    = 1'b0;
        mem_to_reg_o     = 1'b0;
        if (!rst_i) begin
            case (state)
                ST_IDLE: begin
                    if (req_valid_i && req_addr_i[0]) begin
                        misaligned_o = 1'b1;
                    end else if (aligned_req) begin
                        data_mem_addr_o  = req_addr_i;
                        data_mem_wdata_o = req_wdata_i[MEM_W-1:0];
                        data_mem_we_o    = req_write_i;
                        data_mem_re_o    = !req_write_i;
                        mem_to_reg_o     = !req_write_i;
                        stall_o          = req_word_i;
                    end
                end
                ST_HIGH: begin
                    data_mem_addr_o  = hi_addr;
                    data_mem_wdata_o = hi_data;
                    data_mem_we_o    = hi_write;
                    data_mem_re_o    = !hi_write;
                    mem_to_reg_o     = !hi_write;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_split.sv
// tb/tb_mem_access_split.sv - randomized and directed bench for mem_access_split with a memory reference model
module tb_mem_access_split;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic        req_word = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        stall, misaligned, we, re, m2r;
    logic [31:0] maddr;
    logic [15:0] mwdata;

    int checks = 0;
    int failures = 0;

    logic [15:0] env_mem [logic [31:0]];
    logic [15:0] ref_mem [logic [31:0]];

    mem_access_split dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .req_valid_i      (req_valid),
        .req_write_i      (req_write),
        .req_word_i       (req_word),
        .req_addr_i       (req_addr),
        .req_wdata_i      (req_wdata),
        .stall_o          (stall),
        .misaligned_o     (misaligned),
        .data_mem_addr_o  (maddr),
        .data_mem_wdata_o (mwdata),
        .data_mem_we_o    (we),
        .data_mem_re_o    (re),
        .mem_to_reg_o     (m2r)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (we) env_mem[maddr] = mwdata;
    end

    function automatic logic [15:0] env_rd(input logic [31:0] a);
        return env_mem.exists(a) ? env_mem[a] : 16'h0000;
    endfunction

    function automatic logic [15:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_mis"},   32'(misaligned), 32'd0);
        chk({tag, "_we"},    32'(we), 32'd0);
        chk({tag, "_re"},    32'(re), 32'd0);
        chk({tag, "_m2r"},   32'(m2r), 32'd0);
        chk({tag, "_addr"},  maddr, 32'd0);
        chk({tag, "_wdata"}, 32'(mwdata), 32'd0);
    endtask

    task automatic chk_beat(input string tag, input logic wr, input logic [31:0] a,
                            input logic [15:0] d, input logic stl);
        chk({tag, "_stall"}, 32'(stall), 32'(stl));
        chk({tag, "_mis"},   32'(misaligned), 32'd0);
        chk({tag, "_we"},    32'(we), 32'(wr));
        chk({tag, "_re"},    32'(re), 32'(!wr));
        chk({tag, "_m2r"},   32'(m2r), 32'(!wr));
        chk({tag, "_addr"},  maddr, a);
        if (wr) chk({tag, "_wdata"}, 32'(mwdata), 32'(d));
    endtask

    task automatic drive(input logic v, input logic wr, input logic wd,
                         input logic [31:0] a, input logic [31:0] d);
        req_valid = v; req_write = wr; req_word = wd; req_addr = a; req_wdata = d;
    endtask

    task automatic idle();
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        chk_quiet("idle");
    endtask

    // One request; a word request spends two cycles, the second with junk on the request inputs.
    task automatic issue(input string tag, input logic wr, input logic wd,
                         input logic [31:0] a, input logic [31:0] d);
        logic [15:0] lo, hi;
        logic [31:0] a_hi;
        lo = 16'h0; hi = 16'h0;
        a_hi = a + 32'd2;
        @(negedge clk);
        drive(1'b1, wr, wd, a, d);
        #2;
        if (a[0]) begin
            chk({tag, "_mis"},   32'(misaligned), 32'd1);
            chk({tag, "_we"},    32'(we), 32'd0);
            chk({tag, "_re"},    32'(re), 32'd0);
            chk({tag, "_stall"}, 32'(stall), 32'd0);
            return;
        end
        chk_beat({tag, "_lo"}, wr, a, d[15:0], wd);
        if (wr) ref_mem[a] = d[15:0];
        else begin
            lo = env_rd(maddr);
            chk({tag, "_lo_rd"}, 32'(lo), 32'(ref_rd(a)));
        end
        if (!wd) return;
        @(negedge clk);
        drive(1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom, $urandom);
        #2;
        chk_beat({tag, "_hi"}, wr, a_hi, d[31:16], 1'b0);
        if (wr) ref_mem[a_hi] = d[31:16];
        else begin
            hi = env_rd(maddr);
            chk({tag, "_word"}, {hi, lo}, {ref_rd(a_hi), ref_rd(a)});
        end
    endtask

    initial begin
        logic [31:0] a;
        logic        wr, wd;
        logic [15:0] lo, hi;

        #2;
        chk_quiet("reset");
        drive(1'b1, 1'b0, 1'b1, 32'h40, 32'h0);
        #1;
        chk_quiet("reset_req");
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b0;
        #2;
        chk_quiet("post_reset");

        issue("st_word", 1'b1, 1'b1, 32'h100, 32'hDEADBEEF);
        idle();
        chk("st_word_mem_lo", 32'(env_rd(32'h100)), 32'h0000BEEF);
        chk("st_word_mem_hi", 32'(env_rd(32'h102)), 32'h0000DEAD);

        env_mem[32'h40] = 16'h5678; ref_mem[32'h40] = 16'h5678;
        env_mem[32'h42] = 16'h1234; ref_mem[32'h42] = 16'h1234;
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 32'h40, 32'h0);
        #2;
        chk_beat("ld_word_lo", 1'b0, 32'h40, 16'h0, 1'b1);
        lo = env_rd(maddr);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        chk_beat("ld_word_hi", 1'b0, 32'h42, 16'h0, 1'b0);
        hi = env_rd(maddr);
        chk("ld_word_wb", {hi, lo}, 32'h12345678);

        issue("st_half0", 1'b1, 1'b0, 32'h10, 32'hFFFF00AA);
        issue("st_half1", 1'b1, 1'b0, 32'h12, 32'h00005511);
        issue("st_half2", 1'b1, 1'b0, 32'h14, 32'h0000C3C3);
        idle();
        chk("st_half_mem0", 32'(env_rd(32'h10)), 32'h000000AA);
        chk("st_half_mem1", 32'(env_rd(32'h12)), 32'h00005511);
        chk("st_half_mem2", 32'(env_rd(32'h14)), 32'h0000C3C3);

        issue("mis_ld", 1'b0, 1'b1, 32'h103, 32'h0);
        idle();

        issue("st_wrap", 1'b1, 1'b1, 32'hFFFFFFFE, 32'hA5A55A5A);
        idle();
        chk("st_wrap_mem", 32'(env_rd(32'h0)), 32'h0000A5A5);

        env_mem[32'h202] = 16'h7777; ref_mem[32'h202] = 16'h7777;
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 32'h200, 32'h99998888);
        #2;
        chk_beat("rst_lo", 1'b1, 32'h200, 16'h8888, 1'b1);
        ref_mem[32'h200] = 16'h8888;
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 32'h300, 32'h11112222);
        #1;
        rst = 1'b1;
        #1;
        chk_quiet("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        issue("after_rst", 1'b0, 1'b1, 32'h200, 32'h0);
        idle();
        chk("rst_hi_kept", 32'(env_rd(32'h202)), 32'h00007777);

        for (int i = 0; i < 40; i++) begin
            a  = 32'h200 + 32'($urandom_range(0, 15)) * 2;
            if ($urandom_range(0, 9) == 0) a = a | 32'h1;
            if ($urandom_range(0, 15) == 0) a = 32'hFFFFFFFE;
            wr = $urandom_range(0, 1) == 1;
            wd = $urandom_range(0, 1) == 1;
            issue($sformatf("rnd%0d", i), wr, wd, a, $urandom);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
